redux_loader: RTL and testbench
===============================

// Module: redux_loader
// PURPOSE
//   Boot-time program writer for the redux core's instruction memory. Accepts a
//   framed byte stream over a valid/ready handshake: SYNC, LEN, LEN payload
//   bytes, then CHECKSUM. Each payload byte is written to consecutive
//   instruction-memory addresses. The core is held in reset until a frame
//   loads with a good checksum, then released. Sits between the host/UART
//   byte source and the writable port of the instruction memory.
// PARAMETERS
//   SYNC       8'hA5  frame start marker
//   START_ADDR 0      first instruction-memory address written
//   MEM_DEPTH  256    instruction-memory size in bytes (<=256)
// PORTS
//   clk        in   1  single clock; all state updates on rising edge
//   reset      in   1  asynchronous, active-low reset
//   in_valid   in   1  source has a byte on in_data
//   in_data    in   8  stream byte
//   in_ready   out  1  loader accepts in_data this cycle
//   reload     in   1  1-cycle pulse; restarts loading from RUN or ERROR
//   prog_we    out  1  instruction-memory write strobe (1 cycle per byte)
//   prog_addr  out  8  instruction-memory write address
//   prog_data  out  8  instruction-memory write data
//   cpu_hold   out  1  1 = hold core in reset; drives core reset logic
//   done       out  1  1 while in RUN
//   error      out  1  1 while in ERROR
//   err_code   out  2  01 len=0, 10 len too large, 11 checksum mismatch
// BEHAVIOUR
//   - reset low: state=WAIT_SYNC, cpu_hold=1, in_ready=0, prog_we=0,
//     prog_addr=0, prog_data=0, done=0, error=0, err_code=0; count, sum, addr=0.
//   - Transfer occurs on a rising edge with in_valid & in_ready. in_ready=1 in
//     WAIT_SYNC/WAIT_LEN/LOAD/WAIT_SUM (reset high), else 0. in_data only
//     sampled on a transfer. in_valid may be held across idle cycles.
//   - WAIT_SYNC: byte==SYNC -> WAIT_LEN; any other byte discarded, stay.
//   - WAIT_LEN: byte==0 -> ERROR err_code=01;
//     byte > MEM_DEPTH-START_ADDR -> ERROR err_code=10;
//     else count=byte, addr=START_ADDR, sum=0 -> LOAD.
//   - LOAD: per transfer, next cycle: prog_we=1, prog_addr=addr,
//     prog_data=byte. sum=sum+byte mod 256, addr++, count--.
//     Last byte (count==1) -> WAIT_SUM. prog_we is a 1-cycle pulse.
//     Back-to-back transfers give consecutive write cycles, no bubbles.
//     prog_addr/prog_data hold last value while prog_we=0.
//   - WAIT_SUM: byte==sum -> RUN; else ERROR err_code=11.
//   - RUN: cpu_hold=0, done=1, in_ready=0.
//   - ERROR: error=1, cpu_hold=1, in_ready=0. err_code held until next reload
//     or reset.
//   - reload=1 in RUN or ERROR -> WAIT_SYNC next cycle: cpu_hold=1, done=0,
//     error=0, err_code=0. reload ignored in all other states.
//   - Latency: the final checksum transfer releases the core one cycle later
//     (cpu_hold falls on the next edge).
//   - Mid-frame reset: frame aborted, return to reset values. Memory already
//     written keeps partial contents; the core stays held.
//   - Max frame: LEN=MEM_DEPTH-START_ADDR. Last write at MEM_DEPTH-1. addr
//     never wraps.
// TESTING
//   1 reset low, valid stream -> in_ready=0, cpu_hold=1, no prog_we; reset
//     high -> in_ready=1 next cycle.
//   2 bytes 00,A5,03,11,22,33,66 back-to-back -> writes 0:11,1:22,2:33 on
//     three consecutive cycles; cpu_hold 1->0, done=1.
//   3 A5,02,10,20,31 -> two writes, then error=1, err_code=11, cpu_hold=1,
//     in_ready=0; reload pulse -> WAIT_SYNC, error=0.
//   4 A5,00 -> err_code=01; with START_ADDR=250, A5,07 -> err_code=10; no
//     prog_we asserted.
//   5 A5,FF plus 255 bytes with random in_valid gaps and correct sum ->
//     exactly 255 writes, addr 0..254, done=1.
//   6 reset pulsed after 2 of 4 payload bytes -> state WAIT_SYNC,
//     cpu_hold=1; a following full frame loads normally.

Source files
------------

// File: rtl/redux_loader.sv
// redux_loader: boot-time framed byte-stream writer for the core's
// instruction memory; holds the core in reset until a frame checks out.
module redux_loader #(
    parameter logic [7:0] SYNC       = 8'hA5,
    parameter int         START_ADDR = 0,
    parameter int         MEM_DEPTH  = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       reload,
    output logic       prog_we,
    output logic [7:0] prog_addr,
    output logic [7:0] prog_data,
    output logic       cpu_hold,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {
        S_WAIT_SYNC,
        S_WAIT_LEN,
        S_LOAD,
        S_WAIT_SUM,
        S_RUN,
        S_ERROR
    } state_e;

    // Longest payload that still fits above START_ADDR; 9 bits so a
    // full 256-byte memory compares correctly against an 8-bit length.
    localparam logic [8:0] MAX_LEN = 9'(MEM_DEPTH - START_ADDR);
    localparam logic [7:0] ADDR0   = 8'(START_ADDR);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_ZERO = 2'b01;
    localparam logic [1:0] ERR_BIG  = 2'b10;
    localparam logic [1:0] ERR_SUM  = 2'b11;

    state_e     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] addr_q, addr_d;
    logic       in_ready_q, in_ready_d;
    logic       prog_we_q, prog_we_d;
    logic [7:0] prog_addr_q, prog_addr_d;
    logic [7:0] prog_data_q, prog_data_d;
    logic       cpu_hold_q, cpu_hold_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic [1:0] err_code_q, err_code_d;

    logic xfer;

    // A byte moves only when the registered ready meets source valid.
    assign xfer = in_valid & in_ready_q;

    // Next-state and next-output computation for the frame parser.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sum_d       = sum_q;
        addr_d      = addr_q;
        prog_we_d   = 1'b0;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        error_d     = error_q;
        err_code_d  = err_code_q;

        unique case (state_q)
            S_WAIT_SYNC: begin
                if (xfer && (in_data == SYNC)) begin
                    state_d = S_WAIT_LEN;
                end
            end

            S_WAIT_LEN: begin
                if (xfer) begin
                    if (in_data == 8'd0) begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        err_code_d = ERR_ZERO;
                    end else if ({1'b0, in_data} > MAX_LEN) begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        err_code_d = ERR_BIG;
                    end else begin
                        state_d = S_LOAD;
                        count_d = in_data;
                        addr_d  = ADDR0;
                        sum_d   = 8'd0;
                    end
                end
            end

            S_LOAD: begin
                if (xfer) begin
                    prog_we_d   = 1'b1;
                    prog_addr_d = addr_q;
                    prog_data_d = in_data;
                    sum_d       = sum_q + in_data;
                    addr_d      = addr_q + 8'd1;
                    count_d     = count_q - 8'd1;
                    if (count_q == 8'd1) begin
                        state_d = S_WAIT_SUM;
                    end
                end
            end

            S_WAIT_SUM: begin
                if (xfer) begin
                    if (in_data == sum_q) begin
                        state_d    = S_RUN;
                        cpu_hold_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        err_code_d = ERR_SUM;
                    end
                end
            end

            S_RUN: begin
                if (reload) begin
                    state_d    = S_WAIT_SYNC;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                end
            end

            S_ERROR: begin
                if (reload) begin
                    state_d    = S_WAIT_SYNC;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                end
            end

            default: begin
                state_d    = S_WAIT_SYNC;
                cpu_hold_d = 1'b1;
                done_d     = 1'b0;
                error_d    = 1'b0;
                err_code_d = ERR_NONE;
            end
        endcase

        // Ready is registered from the state being entered, so it is
        // low throughout reset and rises on the first edge after it.
        in_ready_d = (state_d == S_WAIT_SYNC) || (state_d == S_WAIT_LEN) ||
                     (state_d == S_LOAD)      || (state_d == S_WAIT_SUM);
    end

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_WAIT_SYNC;
            count_q     <= 8'd0;
            sum_q       <= 8'd0;
            addr_q      <= 8'd0;
            in_ready_q  <= 1'b0;
            prog_we_q   <= 1'b0;
            prog_addr_q <= 8'd0;
            prog_data_q <= 8'd0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            addr_q      <= addr_d;
            in_ready_q  <= in_ready_d;
            prog_we_q   <= prog_we_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign prog_we   = prog_we_q;
    assign prog_addr = prog_addr_q;
    assign prog_data = prog_data_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_redux_loader.sv
// tb_redux_loader: randomized frames against a queue-based frame model,
// plus directed frames with literal expectations.
module tb_redux_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       reload = 1'b0;
    logic       in_ready, prog_we, cpu_hold, done, error;
    logic [7:0] prog_addr, prog_data;
    logic [1:0] err_code;

    logic       v2 = 1'b0;
    logic [7:0] d2 = 8'h00;
    logic       reload2 = 1'b0;
    logic       in_ready2, prog_we2, cpu_hold2, done2, error2;
    logic [7:0] prog_addr2, prog_data2;
    logic [1:0] err_code2;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    always #5 clk = ~clk;

    redux_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .reload(reload), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .cpu_hold(cpu_hold),
        .done(done), .error(error), .err_code(err_code)
    );

    redux_loader #(.START_ADDR(250)) dut2 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_data(d2),
        .in_ready(in_ready2), .reload(reload2), .prog_we(prog_we2),
        .prog_addr(prog_addr2), .prog_data(prog_data2), .cpu_hold(cpu_hold2),
        .done(done2), .error(error2), .err_code(err_code2)
    );

    // ---------------- behavioural model (dut, START_ADDR=0) ----------------
    // m_mode: 0 hunting for sync, 1 inside a frame, 2 running, 3 error.
    // fr holds the frame after sync: fr[0]=LEN, then payload bytes.
    localparam int MAXLEN = 256;
    logic [7:0] fr[$];
    int         m_mode = 0;
    logic       m_rdy = 1'b0;
    logic [1:0] m_code = 2'b00;
    logic       m_we = 1'b0;
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_data = 8'h00;
    bit         m_xfer;

    function automatic logic [7:0] frame_sum();
        logic [7:0] s = 8'h00;
        for (int i = 1; i < fr.size(); i++) s += fr[i];
        return s;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; fr.delete(); m_rdy = 1'b0; m_code = 2'b00;
            m_we = 1'b0; m_addr = 8'h00; m_data = 8'h00;
        end else begin
            m_xfer = in_valid && m_rdy;
            m_we = 1'b0;
            case (m_mode)
                0: if (m_xfer && in_data == 8'hA5) begin
                    m_mode = 1; fr.delete();
                end
                1: if (m_xfer) begin
                    if (fr.size() == 0) begin
                        if (in_data == 8'h00) begin
                            m_mode = 3; m_code = 2'b01;
                        end else if (int'(in_data) > MAXLEN) begin
                            m_mode = 3; m_code = 2'b10;
                        end else fr.push_back(in_data);
                    end else if (fr.size() <= int'(fr[0])) begin
                        fr.push_back(in_data);
                        m_we = 1'b1;
                        m_addr = 8'(fr.size() - 2);
                        m_data = in_data;
                    end else if (in_data == frame_sum()) begin
                        m_mode = 2;
                    end else begin
                        m_mode = 3; m_code = 2'b11;
                    end
                end
                default: if (reload) begin
                    m_mode = 0; m_code = 2'b00;
                end
            endcase
            m_rdy = (m_mode <= 1);
        end
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endfunction

    // ---------------- per-cycle compare + write logs ----------------
    int         wcyc[$];
    logic [7:0] wad[$];
    logic [7:0] wdat[$];
    int         w2cnt = 0;
    logic [7:0] w2last = 8'h00;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, m_rdy);
            chk("cpu_hold", cpu_hold, m_mode != 2);
            chk("done", done, m_mode == 2);
            chk("error", error, m_mode == 3);
            chk("err_code", err_code, m_code);
            chk("prog_we", prog_we, m_we);
            chk("prog_addr", prog_addr, m_addr);
            chk("prog_data", prog_data, m_data);
            if (prog_we) begin
                wcyc.push_back(cyc); wad.push_back(prog_addr);
                wdat.push_back(prog_data);
            end
            if (prog_we2) begin
                w2cnt++; w2last = prog_addr2;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] b, input int maxgap);
        int n;
        int g;
        g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
        repeat (g) begin
            in_valid = 1'b0;
            reload = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        reload = 1'b0;
        in_valid = 1'b1;
        in_data = b;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk); n++;
        end
        if (n >= 20) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout byte %0h: in_ready stayed 0, expected 1", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        chk("dut2_ready", in_ready2, 1);
        v2 = 1'b1; d2 = b;
        @(negedge clk);
        v2 = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        @(negedge clk);
    endtask

    task automatic rand_frame();
        int len;
        int g;
        logic [7:0] s;
        logic [7:0] b;
        g = $urandom_range(0, 2);
        repeat (g) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            send(b, 2);
        end
        send(8'hA5, 2);
        len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 24);
        send(8'(len), 2);
        if (len == 0) return;
        s = 8'h00;
        repeat (len) begin
            b = 8'($urandom);
            s += b;
            send(b, 2);
        end
        send(($urandom_range(0, 3) == 0) ? s + 8'd1 : s, 2);
    endtask

    // ---------------- main sequence ----------------
    logic [7:0] s5;
    logic [7:0] b5;

    initial begin
        // 1: reset low with a valid stream offered
        #1 reset = 1'b0;
        #1 chk_en = 1'b1;
        in_valid = 1'b1; in_data = 8'hA5;
        repeat (4) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cpu_hold", cpu_hold, 1);
        in_valid = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);

        // 2: good 3-byte frame, back to back
        wcyc.delete(); wad.delete(); wdat.delete();
        send(8'h00, 0); send(8'hA5, 0); send(8'h03, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h66, 0);
        chk("t2_nwrites", wad.size(), 3);
        if (wad.size() == 3) begin
            chk("t2_a0", wad[0], 8'h00); chk("t2_d0", wdat[0], 8'h11);
            chk("t2_a1", wad[1], 8'h01); chk("t2_d1", wdat[1], 8'h22);
            chk("t2_a2", wad[2], 8'h02); chk("t2_d2", wdat[2], 8'h33);
            chk("t2_gap1", wcyc[1] - wcyc[0], 1);
            chk("t2_gap2", wcyc[2] - wcyc[1], 1);
        end
        chk("t2_cpu_hold", cpu_hold, 0);
        chk("t2_done", done, 1);

        // 3: bad checksum, then reload
        pulse_reload();
        wad.delete();
        send(8'hA5, 0); send(8'h02, 0); send(8'h10, 0);
        send(8'h20, 0); send(8'h31, 0);
        chk("t3_nwrites", wad.size(), 2);
        chk("t3_error", error, 1);
        chk("t3_err_code", err_code, 2'b11);
        chk("t3_in_ready", in_ready, 0);
        pulse_reload();
        chk("t3_reload_err", error, 0);
        chk("t3_reload_rdy", in_ready, 1);

        // 4: zero length; too long for START_ADDR=250; max fit there
        wad.delete();
        send(8'hA5, 0); send(8'h00, 0);
        chk("t4_err_code", err_code, 2'b01);
        chk("t4_nwrites", wad.size(), 0);
        pulse_reload();
        send2(8'hA5); send2(8'h07);
        chk("t4b_err_code", err_code2, 2'b10);
        chk("t4b_error", error2, 1);
        chk("t4b_nwrites", w2cnt, 0);
        reload2 = 1'b1; @(negedge clk); reload2 = 1'b0; @(negedge clk);
        send2(8'hA5); send2(8'h06);
        for (int i = 1; i <= 6; i++) send2(8'(i));
        send2(8'h15);
        chk("t4c_done", done2, 1);
        chk("t4c_nwrites", w2cnt, 6);
        chk("t4c_last_addr", w2last, 8'hFF);

        // 5: 255-byte frame with random gaps
        wad.delete();
        send(8'hA5, 3); send(8'hFF, 3);
        s5 = 8'h00;
        repeat (255) begin
            b5 = 8'($urandom); s5 += b5; send(b5, 3);
        end
        send(s5, 3);
        chk("t5_nwrites", wad.size(), 255);
        if (wad.size() == 255) begin
            chk("t5_first", wad[0], 8'h00);
            chk("t5_last", wad[254], 8'hFE);
        end
        chk("t5_done", done, 1);

        // 6: reset mid-frame, then a full frame
        pulse_reload();
        send(8'hA5, 0); send(8'h04, 0); send(8'h01, 0); send(8'h02, 0);
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        chk("t6_hold", cpu_hold, 1);
        chk("t6_rdy", in_ready, 0);
        chk("t6_addr", prog_addr, 8'h00);
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk);
        send(8'hA5, 1); send(8'h04, 1);
        send(8'h0A, 1); send(8'h0B, 1); send(8'h0C, 1); send(8'h0D, 1);
        send(8'h2E, 1);
        chk("t6_done", done, 1);

        // random frames
        repeat (40) begin
            pulse_reload();
            rand_frame();
            in_valid = 1'b1; in_data = 8'($urandom);
            repeat (3) @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
